digest_byte_tx: RTL and testbench

DIGEST_BYTE_TX -- requirements
Module: digest_byte_tx

---
 rtl/digest_byte_tx.sv | 147 ++++++++++++++
 tb/tb_digest_byte_tx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/digest_byte_tx.sv
// digest_byte_tx: serialises finished 256-bit digests into a 32-byte valid/ready stream.
// Latency: byte 0 is presented one cycle after din_vld; back-to-back digests stream with no gap.
// Backpressure: tx_rdy low holds the current byte; one further digest is queued, any more are dropped and flagged.
//
// Ports:
//   clk, rst       - single clock, synchronous active-high reset
//   din_vld, din   - one-cycle pulse plus 256-bit digest word
//   tx_data/tx_vld/tx_rdy/tx_last - byte stream out, tx_last marks byte 31
//   busy           - a digest is being sent or waiting
//   overflow       - sticky: a digest arrived while both slots were full
module digest_byte_tx #(
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         din_vld,
  input  logic [255:0] din,
  output logic [7:0]   tx_data,
  output logic         tx_vld,
  input  logic         tx_rdy,
  output logic         tx_last,
  output logic         busy,
  output logic         overflow
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t       state_q,    state_d;
  logic [255:0] act_q,      act_d;
  logic         act_vld_q,  act_vld_d;
  logic [255:0] pend_q,     pend_d;
  logic         pend_vld_q, pend_vld_d;
  logic [4:0]   cnt_q,      cnt_d;
  logic         ovf_q,      ovf_d;

  logic         xfer;
  logic         wrap;
  logic [255:0] act_shift;
  logic [7:0]   sel_byte;

  // All stream outputs come from registers only, so tx_rdy never reaches them.
  assign tx_vld   = (state_q == SEND);
  assign tx_last  = tx_vld && (cnt_q == 5'd31);
  assign tx_data  = tx_vld ? sel_byte : 8'h00;
  assign busy     = act_vld_q | pend_vld_q;
  assign overflow = ovf_q;

  assign xfer = tx_vld & tx_rdy;
  assign wrap = xfer & (cnt_q == 5'd31);

  // Byte select by shifting: for MSB-first order, byte index i lives at
  // bit offset 8*(31-i), and 31-i equals ~i in 5 bits.
  always_comb begin
    if (MSB_FIRST != 0) begin
      act_shift = act_q >> {~cnt_q, 3'b000};
    end else begin
      act_shift = act_q >> {cnt_q, 3'b000};
    end
    sel_byte = act_shift[7:0];
  end

  // Next-state and datapath load decisions.
  always_comb begin
    state_d    = state_q;
    act_d      = act_q;
    act_vld_d  = act_vld_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;

    case (state_q)
      IDLE: begin
        // Pending is always empty here: it is promoted before going idle.
        if (din_vld) begin
          act_d     = din;
          act_vld_d = 1'b1;
          cnt_d     = 5'd0;
          state_d   = SEND;
        end
      end

      SEND: begin
        if (wrap) begin
          cnt_d = 5'd0;
          if (pend_vld_q) begin
            // Promote the queued digest; a digest arriving now takes
            // the slot that was just vacated.
            act_d = pend_q;
            if (din_vld) begin
              pend_d = din;
            end else begin
              pend_vld_d = 1'b0;
            end
          end else if (din_vld) begin
            // Queue empty: the new digest goes straight to active.
            act_d = din;
          end else begin
            act_vld_d = 1'b0;
            state_d   = IDLE;
          end
        end else begin
          if (xfer) begin
            cnt_d = cnt_q + 5'd1;
          end
          if (din_vld) begin
            if (!pend_vld_q) begin
              pend_d     = din;
              pend_vld_d = 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d   = IDLE;
        act_vld_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      act_q      <= '0;
      act_vld_q  <= 1'b0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      cnt_q      <= 5'd0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      act_q      <= act_d;
      act_vld_q  <= act_vld_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_digest_byte_tx.sv
// tb_digest_byte_tx: directed checks of digest_byte_tx byte order, queueing, overflow and reset.
// Two instances share inputs: MSB-first (main) and LSB-first (order check only).
// Outputs are sampled and inputs driven on the falling clock edge.
module tb_digest_byte_tx;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         din_vld = 1'b0;
  logic [255:0] din = '0;
  logic         tx_rdy = 1'b0;
  logic [7:0]   tx_data;
  logic         tx_vld, tx_last, busy, overflow;
  logic [7:0]   l_tx_data;
  logic         l_tx_vld, l_tx_last, l_busy, l_overflow;

  int total = 0;
  int bad   = 0;

  logic [255:0] dig_a, dig_b, dig_c;
  logic [7:0]   exp_q[$];
  int           got_n;
  bit           stall_prev;
  logic [7:0]   prev_data;
  logic         prev_last;

  always #5 clk = ~clk;

  digest_byte_tx #(.MSB_FIRST(1)) u_dut (
    .clk(clk), .rst(rst), .din_vld(din_vld), .din(din),
    .tx_data(tx_data), .tx_vld(tx_vld), .tx_rdy(tx_rdy), .tx_last(tx_last),
    .busy(busy), .overflow(overflow)
  );

  digest_byte_tx #(.MSB_FIRST(0)) u_dut_lsb (
    .clk(clk), .rst(rst), .din_vld(din_vld), .din(din),
    .tx_data(l_tx_data), .tx_vld(l_tx_vld), .tx_rdy(tx_rdy), .tx_last(l_tx_last),
    .busy(l_busy), .overflow(l_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push_digest(input logic [255:0] d);
    for (int i = 0; i < 32; i++) exp_q.push_back(d[255-8*i -: 8]);
  endtask

  task automatic do_reset();
    rst = 1'b1; din_vld = 1'b0; tx_rdy = 1'b0;
    step(); step();
    chk("rst_vld",  {31'd0, tx_vld},   32'd0);
    chk("rst_data", {24'd0, tx_data},  32'd0);
    chk("rst_last", {31'd0, tx_last},  32'd0);
    chk("rst_busy", {31'd0, busy},     32'd0);
    chk("rst_ovf",  {31'd0, overflow}, 32'd0);
    rst = 1'b0;
  endtask

  // Per-cycle monitor: compares against the expected byte queue, checks
  // hold-during-stall, then picks tx_rdy for the coming edge.
  task automatic mon(input bit rnd, input bit contig, input int n);
    if (stall_prev) begin
      chk("hold_vld",  {31'd0, tx_vld},  32'd1);
      chk("hold_data", {24'd0, tx_data}, {24'd0, prev_data});
      chk("hold_last", {31'd0, tx_last}, {31'd0, prev_last});
    end
    if (contig && got_n > 0 && got_n < n) chk("gap", {31'd0, tx_vld}, 32'd1);
    if (tx_vld) begin
      if (got_n < n) begin
        chk("data", {24'd0, tx_data}, {24'd0, exp_q[got_n]});
        chk("last", {31'd0, tx_last}, {31'd0, (got_n % 32) == 31});
      end else begin
        chk("extra_byte", {31'd0, tx_vld}, 32'd0);
      end
    end
    tx_rdy     = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    stall_prev = tx_vld && !tx_rdy;
    prev_data  = tx_data;
    prev_last  = tx_last;
    if (tx_vld && tx_rdy) got_n++;
  endtask

  // Sends dig_a, then injects dig_b / dig_c at the given cycle indices
  // (cycle 0 = first cycle with byte 0 of A visible). ovf_at < 0 means
  // overflow must stay low; otherwise it must rise the cycle after ovf_at.
  task automatic stream(input int n, input bit rnd, input bit contig,
                        input int inj_b, input int inj_c, input int ovf_at);
    got_n = 0; stall_prev = 1'b0;
    din = dig_a; din_vld = 1'b1; tx_rdy = 1'b1;
    step();
    din_vld = 1'b0;
    for (int cyc = 0; cyc < 3000 && got_n < n; cyc++) begin
      mon(rnd, contig, n);
      if (ovf_at >= 0) chk("ovf", {31'd0, overflow}, {31'd0, cyc > ovf_at});
      else             chk("ovf", {31'd0, overflow}, 32'd0);
      din_vld = (cyc == inj_b) || (cyc == inj_c);
      din     = (cyc == inj_b) ? dig_b : dig_c;
      step();
    end
    din_vld = 1'b0;
    chk("count", got_n, n);
    chk("end_vld",  {31'd0, tx_vld}, 32'd0);
    chk("end_busy", {31'd0, busy},   32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      dig_a[255-8*i -: 8] = 8'(i);
      dig_b[255-8*i -: 8] = 8'(8'h40 + i);
      dig_c[255-8*i -: 8] = 8'(8'hA0 + i);
    end

    // Single digest, both byte orders, tx_rdy held high.
    do_reset();
    din = dig_a; din_vld = 1'b1; tx_rdy = 1'b1;
    step();
    din_vld = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk("single_vld",   {31'd0, tx_vld},    32'd1);
      chk("single_data",  {24'd0, tx_data},   32'(i));
      chk("single_last",  {31'd0, tx_last},   {31'd0, i == 31});
      chk("lsb_data",     {24'd0, l_tx_data}, 32'(31 - i));
      chk("lsb_last",     {31'd0, l_tx_last}, {31'd0, i == 31});
      step();
    end
    chk("single_idle_vld",  {31'd0, tx_vld},  32'd0);
    chk("single_idle_data", {24'd0, tx_data}, 32'd0);
    chk("single_idle_busy", {31'd0, busy},    32'd0);
    chk("lsb_idle_vld",     {31'd0, l_tx_vld}, 32'd0);

    // Random backpressure, A then B queued.
    do_reset();
    exp_q.delete(); push_digest(dig_a); push_digest(dig_b);
    stream(64, 1'b1, 1'b0, 10, -1, -1);

    // B arrives at byte 5 of A: 64 contiguous transfers.
    do_reset();
    exp_q.delete(); push_digest(dig_a); push_digest(dig_b);
    stream(64, 1'b0, 1'b1, 5, -1, -1);

    // B arrives exactly on A's last transfer with queue empty.
    do_reset();
    exp_q.delete(); push_digest(dig_a); push_digest(dig_b);
    stream(64, 1'b0, 1'b1, 31, -1, -1);

    // B queued, C arrives on A's last transfer: nothing lost.
    do_reset();
    exp_q.delete(); push_digest(dig_a); push_digest(dig_b); push_digest(dig_c);
    stream(96, 1'b0, 1'b1, 3, 31, -1);

    // A, B, C while A still sending: C dropped, overflow sticky.
    do_reset();
    exp_q.delete(); push_digest(dig_a); push_digest(dig_b);
    stream(64, 1'b0, 1'b1, 3, 6, 6);
    step();
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Reset at byte 10 with pending valid and overflow set.
    do_reset();
    got_n = 0;
    din = dig_a; din_vld = 1'b1; tx_rdy = 1'b1;
    step();
    for (int cyc = 0; cyc < 10; cyc++) begin
      din_vld = (cyc == 2) || (cyc == 4);
      din     = (cyc == 2) ? dig_b : dig_c;
      step();
    end
    chk("pre_rst_data", {24'd0, tx_data},  32'd10);
    chk("pre_rst_ovf",  {31'd0, overflow}, 32'd1);
    rst = 1'b1; din = dig_c; din_vld = 1'b1;
    step();
    chk("rst_mid_vld",  {31'd0, tx_vld},   32'd0);
    chk("rst_mid_busy", {31'd0, busy},     32'd0);
    chk("rst_mid_ovf",  {31'd0, overflow}, 32'd0);
    chk("rst_mid_data", {24'd0, tx_data},  32'd0);
    rst = 1'b0; din = dig_b; din_vld = 1'b1;
    step();
    din_vld = 1'b0;
    exp_q.delete(); push_digest(dig_b);
    got_n = 0; stall_prev = 1'b0;
    chk("post_rst_vld", {31'd0, tx_vld}, 32'd1);
    for (int cyc = 0; cyc < 200 && got_n < 32; cyc++) begin
      mon(1'b0, 1'b1, 32);
      step();
    end
    chk("post_rst_count", got_n, 32);
    chk("post_rst_idle",  {31'd0, tx_vld}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
